// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Integer register file with two combinational read ports, one
//               synchronous write port and a per-register busy scoreboard that
//               flags read-after-write hazards to the issue stage.
//               Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback
//               data and busy-clear to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            hazard,
   input  logic            issue_en,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ack,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   output logic [AW:0]     busy_count
);

   localparam logic c_zero_hw = (ZERO_REG != 0);

   logic [XLEN-1:0] r_mem [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [AW:0]      r_busy_count;

   logic             w_rs1_zero;
   logic             w_rs2_zero;
   logic             w_rs1_byp;
   logic             w_rs2_byp;
   logic             w_wr_ok;
   logic             w_issue_set;
   logic [NREGS-1:0] w_busy_next;
   logic [AW:0]      w_pop;

   assign w_rs1_zero  = c_zero_hw && (rs1_addr == '0);
   assign w_rs2_zero  = c_zero_hw && (rs2_addr == '0);
   assign w_wr_ok     = wr_en && !(c_zero_hw && (wr_addr == '0));

`ifdef REGFILE_BYPASS_EN
   // w_wr_ok already excludes the hardwired register, so no bypass onto it
   assign w_rs1_byp = w_wr_ok && (wr_addr == rs1_addr);
   assign w_rs2_byp = w_wr_ok && (wr_addr == rs2_addr);
`else
   assign w_rs1_byp = 1'b0;
   assign w_rs2_byp = 1'b0;
`endif

   assign rs1_data = w_rs1_zero ? '0 : (w_rs1_byp ? wr_data : r_mem[rs1_addr]);
   assign rs2_data = w_rs2_zero ? '0 : (w_rs2_byp ? wr_data : r_mem[rs2_addr]);
   assign rs1_busy = !w_rs1_zero && !w_rs1_byp && r_busy[rs1_addr];
   assign rs2_busy = !w_rs2_zero && !w_rs2_byp && r_busy[rs2_addr];

   assign hazard      = rs1_busy || rs2_busy;
   assign issue_ack   = issue_en && !hazard;
   assign w_issue_set = issue_ack && !(c_zero_hw && (issue_rd == '0));

   // Set is applied after clear: a new producer issued in the same cycle as
   // the old one's writeback keeps the register pending.
   always_comb begin
      w_busy_next = r_busy;
      if (w_wr_ok) begin
         w_busy_next[wr_addr] = 1'b0;
      end
      if (w_issue_set) begin
         w_busy_next[issue_rd] = 1'b1;
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NREGS; i++) begin
         w_pop = w_pop + {{AW{1'b0}}, w_busy_next[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy       <= '0;
         r_busy_count <= '0;
      end else begin
         r_busy       <= w_busy_next;
         r_busy_count <= w_pop;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign busy_count = r_busy_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// Self-checking bench for regfile_scoreboard (default parameters).
// Expected values are queued at stimulus time and compared when outputs are sampled.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1_addr, rs2_addr, issue_rd, wr_addr;
   logic [31:0] rs1_data, rs2_data, wr_data;
   logic        rs1_busy, rs2_busy, hazard, issue_en, issue_ack, wr_en;
   logic [5:0]  busy_count;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] obs_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   regfile_scoreboard dut (
      .clk(clk), .reset(reset),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .hazard(hazard),
      .issue_en(issue_en), .issue_rd(issue_rd), .issue_ack(issue_ack),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
      wr_addr = '0; wr_data = '0; issue_rd = '0;
      rs1_addr = '0; rs2_addr = '0;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [31:0] o;
      idle();
      reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
      issue_en = 1'b1; issue_rd = 5'd2;
      tick(); tick();
      idle();
      #1;
      exp_q.push_back('{"rst_busy_count", 32'd0});
      obs_q.push_back(32'(busy_count));
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
         #1;
         exp_q.push_back('{$sformatf("rst_rs1_data[%0d]", a), 32'd0});
         obs_q.push_back(rs1_data);
         exp_q.push_back('{$sformatf("rst_rs2_data[%0d]", 31 - a), 32'd0});
         obs_q.push_back(rs2_data);
         exp_q.push_back('{$sformatf("rst_busy_pair[%0d]", a), 32'd0});
         obs_q.push_back({29'd0, hazard, rs1_busy, rs2_busy});
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e.val) begin
            n_err++; $display("FAIL %s: got %h expected %h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_write();
      exp_t e;
      logic [31:0] o;
      idle();
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
      exp_q.push_back('{"wr5_read", 32'hDEAD_BEEF});
      tick();
      wr_en = 1'b0; rs1_addr = 5'd5; #1;
      obs_q.push_back(rs1_data);
      wr_addr = 5'd5; wr_data = 32'h0BAD_0BAD;
      exp_q.push_back('{"wr_en0_keeps", 32'hDEAD_BEEF});
      tick();
      rs2_addr = 5'd5; #1;
      obs_q.push_back(rs2_data);
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
      tick();
      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5_A5A5;
      exp_q.push_back('{"zero_reg_rs1", 32'd0});
      exp_q.push_back('{"zero_reg_rs2", 32'd0});
      tick();
      wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_0001;
      rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
      obs_q.push_back(rs1_data); obs_q.push_back(rs2_data);
      exp_q.push_back('{"wr31_read", 32'hA5A5_A5A5});
      exp_q.push_back('{"wr1_read", 32'h0000_0001});
      tick();
      wr_en = 1'b0; rs1_addr = 5'd31; rs2_addr = 5'd1; #1;
      obs_q.push_back(rs1_data); obs_q.push_back(rs2_data);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e.val) begin
            n_err++; $display("FAIL %s: got %h expected %h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_issue();
      exp_t e;
      logic [31:0] o;
      idle();
      issue_en = 1'b1; issue_rd = 5'd7; #1;
      exp_q.push_back('{"issue7_ack", 32'd1});
      obs_q.push_back({31'd0, issue_ack});
      tick();
      exp_q.push_back('{"issue7_count", 32'd1});
      obs_q.push_back(32'(busy_count));
      rs2_addr = 5'd7; issue_rd = 5'd8; #1;
      exp_q.push_back('{"raw7_hazard_ack_busy", 32'b101});
      obs_q.push_back({29'd0, hazard, issue_ack, rs2_busy});
      tick();
      exp_q.push_back('{"stall_count", 32'd1});
      obs_q.push_back(32'(busy_count));
      issue_en = 1'b0; rs2_addr = 5'd0;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0077;
      tick();
      wr_en = 1'b0; rs2_addr = 5'd7; #1;
      exp_q.push_back('{"wb7_busy", 32'd0});
      obs_q.push_back({31'd0, rs2_busy});
      exp_q.push_back('{"wb7_count", 32'd0});
      obs_q.push_back(32'(busy_count));
      exp_q.push_back('{"wb7_data", 32'h0000_0077});
      obs_q.push_back(rs2_data);
      rs2_addr = 5'd0; issue_en = 1'b1; issue_rd = 5'd0; #1;
      exp_q.push_back('{"issue0_ack", 32'd1});
      obs_q.push_back({31'd0, issue_ack});
      tick();
      issue_en = 1'b0;
      exp_q.push_back('{"issue0_count", 32'd0});
      obs_q.push_back(32'(busy_count));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e.val) begin
            n_err++; $display("FAIL %s: got %h expected %h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_issue_write_same();
      exp_t e;
      logic [31:0] o;
      idle();
      issue_en = 1'b1; issue_rd = 5'd3;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_00AA; #1;
      exp_q.push_back('{"same3_ack", 32'd1});
      obs_q.push_back({31'd0, issue_ack});
      tick();
      issue_en = 1'b0; wr_en = 1'b0; rs1_addr = 5'd3; #1;
      exp_q.push_back('{"same3_data", 32'h0000_00AA});
      obs_q.push_back(rs1_data);
      exp_q.push_back('{"same3_busy", 32'd1});
      obs_q.push_back({31'd0, rs1_busy});
      exp_q.push_back('{"same3_count", 32'd1});
      obs_q.push_back(32'(busy_count));
      // set one register while clearing another: count must stay at 1
      rs1_addr = 5'd0;
      issue_en = 1'b1; issue_rd = 5'd10;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_00BB;
      tick();
      exp_q.push_back('{"swap_count", 32'd1});
      obs_q.push_back(32'(busy_count));
      wr_en = 1'b0; issue_rd = 5'd10;
      tick();
      issue_en = 1'b0;
      exp_q.push_back('{"waw10_count", 32'd1});
      obs_q.push_back(32'(busy_count));
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1010_1010;
      tick();
      wr_en = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd3; #1;
      exp_q.push_back('{"waw10_clear_count", 32'd0});
      obs_q.push_back(32'(busy_count));
      exp_q.push_back('{"waw10_busy_pair", 32'd0});
      obs_q.push_back({30'd0, rs1_busy, rs2_busy});
      exp_q.push_back('{"rd3_after_swap", 32'h0000_00BB});
      obs_q.push_back(rs2_data);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e.val) begin
            n_err++; $display("FAIL %s: got %h expected %h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_bypass();
      exp_t e;
      logic [31:0] o;
      idle();
      issue_en = 1'b1; issue_rd = 5'd9;
      tick();
      issue_rd = 5'd11;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0055;
      rs1_addr = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back('{"byp9_data", 32'h0000_0055});
      exp_q.push_back('{"byp9_busy_hz_ack", 32'b001});
`else
      exp_q.push_back('{"byp9_data", 32'h0000_0000});
      exp_q.push_back('{"byp9_busy_hz_ack", 32'b110});
`endif
      obs_q.push_back(rs1_data);
      obs_q.push_back({29'd0, rs1_busy, hazard, issue_ack});
      tick();
      issue_en = 1'b0; wr_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back('{"byp9_count", 32'd1});
`else
      exp_q.push_back('{"byp9_count", 32'd0});
`endif
      obs_q.push_back(32'(busy_count));
      wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h0000_0011;
      tick();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
      rs1_addr = 5'd0; rs2_addr = 5'd9; #1;
      exp_q.push_back('{"no_byp_reg0", 32'd0});
      obs_q.push_back(rs1_data);
      exp_q.push_back('{"rd9_after", 32'h0000_0055});
      obs_q.push_back(rs2_data);
      exp_q.push_back('{"rd9_after_busy", 32'd0});
      obs_q.push_back({31'd0, rs2_busy});
      exp_q.push_back('{"after_byp_count", 32'd0});
      obs_q.push_back(32'(busy_count));
      tick();
      wr_en = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e.val) begin
            n_err++; $display("FAIL %s: got %h expected %h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_reset_concurrent();
      exp_t e;
      logic [31:0] o;
      idle();
      wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hCAFE_F00D;
      tick();
      wr_en = 1'b0;
      for (int r = 12; r < 16; r++) begin
         issue_en = 1'b1; issue_rd = 5'(r);
         tick();
      end
      issue_en = 1'b0;
      exp_q.push_back('{"four_busy_count", 32'd4});
      obs_q.push_back(32'(busy_count));
      reset = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hFFFF_0000;
      issue_en = 1'b1; issue_rd = 5'd21;
      tick();
      idle();
      rs1_addr = 5'd20; rs2_addr = 5'd5; #1;
      exp_q.push_back('{"rstc_count", 32'd0});
      obs_q.push_back(32'(busy_count));
      exp_q.push_back('{"rstc_rd20", 32'd0});
      obs_q.push_back(rs1_data);
      exp_q.push_back('{"rstc_rd5", 32'd0});
      obs_q.push_back(rs2_data);
      rs1_addr = 5'd12; rs2_addr = 5'd21; #1;
      exp_q.push_back('{"rstc_busy_pair", 32'd0});
      obs_q.push_back({30'd0, rs1_busy, rs2_busy});
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e.val) begin
            n_err++; $display("FAIL %s: got %h expected %h", e.name, o, e.val);
         end
      end
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_write();
      test_issue();
      test_issue_write_same();
      test_bypass();
      test_reset_concurrent();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
